// File: rtl/hsid_x_word_unpacker.sv
// Word FIFO + element splitter between the OBI reader word stream and the distance datapath.
// Optional HSID_X_UNPACK_MSB_FIRST_EN emits the most significant element of each word first.
module hsid_x_word_unpacker #(
  parameter int WORD_WIDTH  = 32,
  parameter int ELEM_WIDTH  = 16,
  parameter int BAND_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [BAND_WIDTH-1:0]  band_count,
  input  logic                   data_in_valid,
  input  logic [WORD_WIDTH-1:0]  data_in,
  output logic                   elem_valid,
  input  logic                   elem_ready,
  output logic [ELEM_WIDTH-1:0]  elem_data,
  output logic                   elem_last_band,
  output logic [PIXEL_WIDTH-1:0] pixel_count,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   idle
);

  localparam int EPW   = WORD_WIDTH / ELEM_WIDTH;
  localparam int SUB_W = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(EPW - 1);
  localparam logic [SUB_W-1:0]      SUB_ONE  = SUB_W'(1);
  localparam logic [PTR_W:0]        CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [BAND_WIDTH-1:0] BAND_ONE = BAND_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic [SUB_W-1:0]       sub_q;
  logic [SUB_W-1:0]       slice_idx;
  logic [BAND_WIDTH-1:0]  band_cnt;
  logic [BAND_WIDTH-1:0]  cur_bands;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic                   overflow_q;

  logic [EPW-1:0][ELEM_WIDTH-1:0] head_elems;
  logic run, xfer, pop, push_req, push, drop, last_hit;

  // FSM: the run never ends by itself; only clear leaves RUN.
  always_comb begin
    state_d = state_q;
    idle    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle = 1'b1;
        if (start && !clear) state_d = ST_RUN;
      end
      ST_RUN:   if (clear) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Stream handshake: an element moves when elem_valid && elem_ready; outputs hold while stalled.
  always_comb begin
    run        = (state_q == ST_RUN);
    head_elems = mem[rd_ptr];
`ifdef HSID_X_UNPACK_MSB_FIRST_EN
    slice_idx  = SUB_LAST - sub_q;
`else
    slice_idx  = sub_q;
`endif
    elem_valid     = run && (count != '0);
    elem_data      = elem_valid ? head_elems[slice_idx] : '0;
    last_hit       = (band_cnt == cur_bands - BAND_ONE);
    elem_last_band = elem_valid && last_hit;
    xfer           = elem_valid && elem_ready;
    pop            = xfer && (sub_q == SUB_LAST);
    fifo_full      = (count == CNT_FULL);
    push_req       = run && data_in_valid;
    // A full FIFO still accepts a word when the head is popped in the same cycle.
    push           = push_req && (!fifo_full || pop);
    drop           = push_req && fifo_full && !pop;
    pixel_count    = pixel_q;
    overflow       = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sub_q      <= '0;
      band_cnt   <= '0;
      cur_bands  <= '0;
      pixel_q    <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sub_q      <= '0;
      band_cnt   <= '0;
      pixel_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start && !clear)
        cur_bands <= (band_count == '0) ? '1 : band_count;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) begin
        sub_q <= (sub_q == SUB_LAST) ? '0 : sub_q + SUB_ONE;
        if (last_hit) begin
          band_cnt <= '0;
          pixel_q  <= pixel_q + 1'b1;
        end else begin
          band_cnt <= band_cnt + BAND_ONE;
        end
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule
